// File: rtl/mips_pkg.sv
// Shared definitions for the Mips core, its decode logic and the fetch stage.
package mips_pkg;

    localparam int MIPS_ADDR_W = 6;
    localparam int MIPS_DATA_W = 32;
    localparam logic [MIPS_DATA_W-1:0] MIPS_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        START  = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/mips_fetch_unit.sv
// Instruction fetch: owns the PC, reads a sync ROM, hands one instruction per cycle to the core.
// Latency: first instr_valid on the 3rd edge after reset release; 2 cycles from redirect to target.
// Backpressure: stall freezes PC and outputs; redirect overrides stall; a consumed HALT_WORD freezes everything.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int                 ADDR_W    = mips_pkg::MIPS_ADDR_W,
    parameter int                 DATA_W    = mips_pkg::MIPS_DATA_W,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [DATA_W-1:0]  HALT_WORD = DATA_W'(mips_pkg::MIPS_HALT_WORD)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] InstructionNum,
    output logic              halted
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] num_q, num_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic [DATA_W-1:0] hold_dat_q, hold_dat_d;
    logic              hold_vld_q, hold_vld_d;
    logic              halt_consumed;

    assign halt_consumed = valid_q && (instr_q == HALT_WORD) && !stall;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_valid_d = fetch_valid_q;
        instr_d       = instr_q;
        num_d         = num_q;
        valid_d       = valid_q;
        halted_d      = halted_q;
        hold_dat_d    = hold_dat_q;
        hold_vld_d    = hold_vld_q;

        case (state_q)
            START: state_d = RUN;
            RUN: begin
                if (halt_consumed) begin
                    state_d  = HALTED;
                    halted_d = 1'b1;
                    valid_d  = 1'b0;
                end else if (branch_taken) begin
                    pc_d          = branch_target;
                    fetch_valid_d = 1'b0;
                    valid_d       = 1'b0;
                    hold_vld_d    = 1'b0;
                end else if (stall) begin
                    // The ROM keeps reading pc while stalled, so the word for
                    // fetch_pc_q is only on imem_data for the first stalled cycle.
                    if (!hold_vld_q) begin
                        hold_dat_d = imem_data;
                        hold_vld_d = 1'b1;
                    end
                end else begin
                    pc_d          = pc_q + ADDR_W'(1);
                    fetch_pc_d    = pc_q;
                    fetch_valid_d = 1'b1;
                    instr_d       = hold_vld_q ? hold_dat_q : imem_data;
                    num_d         = fetch_pc_q;
                    valid_d       = fetch_valid_q;
                    hold_vld_d    = 1'b0;
                end
            end
            HALTED: ;
            default: state_d = START;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= START;
            pc_q          <= RESET_PC;
            fetch_pc_q    <= '0;
            fetch_valid_q <= 1'b0;
            instr_q       <= '0;
            num_q         <= '0;
            valid_q       <= 1'b0;
            halted_q      <= 1'b0;
            hold_dat_q    <= '0;
            hold_vld_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_valid_q <= fetch_valid_d;
            instr_q       <= instr_d;
            num_q         <= num_d;
            valid_q       <= valid_d;
            halted_q      <= halted_d;
            hold_dat_q    <= hold_dat_d;
            hold_vld_q    <= hold_vld_d;
        end
    end

    assign imem_addr      = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = valid_q;
    assign InstructionNum = num_q;
    assign halted         = halted_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: behavioural sync ROM, address-stream model, directed scenarios.
module tb_mips_fetch_unit;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [5:0]  branch_target = '0;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [5:0]  InstructionNum;
    logic        halted;

    int errors = 0;
    int checks = 0;

    logic [31:0] rom [64];

    mips_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .InstructionNum (InstructionNum),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= rom[imem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Address-stream model: m_next is the address the stage will ask for,
    // m_inflight the address whose data arrives next, m_out what the core sees (-1 = nothing).
    int m_next, m_inflight, m_out, m_last;
    bit m_started, m_halted;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_next = 0; m_inflight = -1; m_out = -1; m_last = 0;
            m_started = 0; m_halted = 0;
        end else if (m_halted) begin
            // frozen
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_out >= 0 && rom[m_out] == HALT && !stall) begin
            m_halted = 1; m_last = m_out; m_out = -1;
        end else if (branch_taken) begin
            m_next = int'(branch_target); m_inflight = -1; m_out = -1;
        end else if (!stall) begin
            m_out = m_inflight; m_inflight = m_next; m_next = (m_next + 1) % 64;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("imem_addr", 32'(imem_addr), m_next);
            check("halted", 32'(halted), 32'(m_halted));
            check("instr_valid", 32'(instr_valid), (m_out >= 0) ? 1 : 0);
            if (m_out >= 0) begin
                check("InstructionNum", 32'(InstructionNum), m_out);
                check("instr", instr, rom[m_out]);
            end
            if (m_halted) begin
                check("frozen_num", 32'(InstructionNum), m_last);
                check("frozen_instr", instr, rom[m_last]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic v, input int num, input logic [31:0] ins);
        check({name, "_valid"}, 32'(instr_valid), 32'(v));
        if (v) begin
            check({name, "_num"}, 32'(InstructionNum), num);
            check({name, "_instr"}, instr, ins);
        end
    endtask

    task automatic startup_check(input string name);
        step(); expect_out({name, "_e1"}, 1'b0, 0, 0);
        step(); expect_out({name, "_e2"}, 1'b0, 0, 0);
        step(); expect_out({name, "_e3"}, 1'b1, 0, 32'h100);
        step(); expect_out({name, "_e4"}, 1'b1, 1, 32'h101);
    endtask

    task automatic check_cleared(input string name);
        check({name, "_valid"}, 32'(instr_valid), 0);
        check({name, "_num"}, 32'(InstructionNum), 0);
        check({name, "_instr"}, instr, 0);
        check({name, "_halted"}, 32'(halted), 0);
        check({name, "_addr"}, 32'(imem_addr), 0);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 64; i++) rom[i] = 32'h100 + i;
        rom[9] = HALT;

        // Reset state, then release and check the 3-edge latency
        repeat (2) @(negedge clk);
        check_cleared("reset");
        reset = 1'b0;
        startup_check("start");
        step(); step(); step();
        expect_out("pre_stall", 1'b1, 4, 32'h104);

        // Stall for three edges while InstructionNum=4
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); expect_out("stall_hold", 1'b1, 4, 32'h104);
        end
        stall = 1'b0;
        step(); expect_out("stall_release", 1'b1, 5, 32'h105);
        step(); expect_out("pre_branch", 1'b1, 6, 32'h106);

        // Redirect to 20
        branch_taken = 1'b1; branch_target = 6'd20;
        step(); branch_taken = 1'b0; branch_target = 6'd0;
        expect_out("branch_bubble1", 1'b0, 0, 0);
        step(); expect_out("branch_bubble2", 1'b0, 0, 0);
        step(); expect_out("branch_t0", 1'b1, 20, 32'h114);
        step(); expect_out("branch_t1", 1'b1, 21, 32'h115);

        // Redirect together with stall: redirect wins
        stall = 1'b1; branch_taken = 1'b1; branch_target = 6'd20;
        step(); branch_taken = 1'b0;
        expect_out("brstall_0", 1'b0, 0, 0);
        step(); step();
        expect_out("brstall_held", 1'b0, 0, 0);
        check("brstall_addr", 32'(imem_addr), 20);
        stall = 1'b0;
        step(); expect_out("brstall_refill", 1'b0, 0, 0);
        step(); expect_out("brstall_t0", 1'b1, 20, 32'h114);

        // Free run to the wrap point
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (instr_valid && InstructionNum == 6'd63) found = 1'b1;
        end
        check("wrap_reached63", 32'(found), 1);
        step(); expect_out("wrap_0", 1'b1, 0, 32'h100);

        // Run into the HALT word at address 9
        repeat (8) step();
        expect_out("pre_halt", 1'b1, 8, 32'h108);
        step(); expect_out("halt_word", 1'b1, 9, HALT);
        step();
        check("halted_set", 32'(halted), 1);
        check("halted_valid", 32'(instr_valid), 0);
        check("halted_addr", 32'(imem_addr), 11);

        // Redirect and stall after halt are ignored
        branch_taken = 1'b1; branch_target = 6'd5; stall = 1'b1;
        step(); branch_taken = 1'b0; stall = 1'b0;
        repeat (4) step();
        check("halt_sticky", 32'(halted), 1);
        check("halt_num", 32'(InstructionNum), 9);
        check("halt_instr", instr, HALT);
        check("halt_addr", 32'(imem_addr), 11);

        // Asynchronous reset between edges clears a halted unit
        @(posedge clk); #2 reset = 1'b1; #1;
        check_cleared("async_rst_halted");
        @(negedge clk); reset = 1'b0;
        startup_check("restart1");
        step();
        expect_out("restart1_e5", 1'b1, 2, 32'h102);

        // Asynchronous reset mid-stream
        @(posedge clk); #2 reset = 1'b1; #1;
        check_cleared("async_rst_run");
        @(negedge clk); reset = 1'b0;
        startup_check("restart2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
